muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_sign_fix.sv | 24 ++
 rtl/muldiv_unit.sv | 123 ++++++++++++
 tb/tb_muldiv_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, funct3 op codes and FSM state type for the iterative RV32M unit.
package muldiv_pkg;
   localparam int XLEN  = 32;
   localparam int CNT_W = 6;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;
endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction and half/word selection of the raw {hi,lo} datapath value.
module muldiv_sign_fix
   import muldiv_pkg::*;
(
   input  logic [2*XLEN-1:0] raw,
   input  logic              neg,
   input  logic [2:0]        op,
   output logic [XLEN-1:0]   res
);
   logic [2*XLEN-1:0] prod_fix;

   // Products negate as a 64-bit whole; quotient/remainder each negate as 32-bit words.
   always_comb begin
      prod_fix = neg ? -raw : raw;
      res      = '0;
      case (op)
         OP_MUL:                       res = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: res = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              res = neg ? -raw[XLEN-1:0] : raw[XLEN-1:0];
         OP_REM, OP_REMU:              res = neg ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
         default:                      res = '0;
      endcase
   end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, 33-cycle start/busy/done handshake.
// Divider is present only when MULDIV_DIV_EN is defined; otherwise ops 1xx return 0 on the fast path.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            CLK,
   input  logic            RST,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op_q;
   logic              neg_q;
   logic [XLEN-1:0]   opb;
   logic [2*XLEN-1:0] prod, prod_nxt;
   logic [XLEN:0]     add;
   logic              a_sgn, b_sgn, s_a, s_b, fast;
   logic [XLEN-1:0]   mag_a, mag_b, fixed;
`ifdef MULDIV_DIV_EN
   logic [XLEN:0]     sh, diff;
`endif

   // Operand signedness from funct3, then magnitudes for the unsigned core.
   always_comb begin
      a_sgn = op[2] ? ~op[0] : (op[1:0] != 2'b11);
      b_sgn = op[2] ? ~op[0] : ~op[1];
      s_a   = a_sgn & A[XLEN-1];
      s_b   = b_sgn & B[XLEN-1];
      mag_a = s_a ? -A : A;
      mag_b = s_b ? -B : B;
`ifdef MULDIV_DIV_EN
      fast  = op[2] & (B == '0);
`else
      fast  = op[2];
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = fast ? S_FIX : S_CALC;
         S_CALC:  if (cnt == CNT_W'(XLEN-1)) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE);
   end

   // prod holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
   always_comb begin
      add      = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opb} : '0);
      prod_nxt = {add, prod[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
      sh   = prod[2*XLEN-1:XLEN-1];
      diff = sh - {1'b0, opb};
      if (op_q[2])
         prod_nxt = {diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0], prod[XLEN-2:0], ~diff[XLEN]};
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt    <= '0;
         op_q   <= '0;
         neg_q  <= 1'b0;
         opb    <= '0;
         prod   <= '0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               op_q <= op;
               cnt  <= '0;
               opb  <= mag_b;
               if (fast) begin
                  neg_q <= 1'b0;
`ifdef MULDIV_DIV_EN
                  // Div-by-zero: quotient all ones, remainder is the dividend.
                  prod  <= {A, {XLEN{1'b1}}};
`else
                  prod  <= '0;
`endif
               end else begin
                  neg_q <= (op[2] & op[1]) ? s_a : (s_a ^ s_b);
                  prod  <= {{XLEN{1'b0}}, mag_a};
               end
            end
            S_CALC: begin
               prod <= prod_nxt;
               cnt  <= cnt + 1'b1;
            end
            S_FIX: begin
               result <= fixed;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   muldiv_sign_fix u_fix (
      .raw (prod),
      .neg (neg_q),
      .op  (op_q),
      .res (fixed)
   );
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corners plus random ops vs. an arithmetic model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A, B;
   logic        busy, done;
   logic [31:0] result;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] prev_res;

   always #5 CLK = ~CLK;

   muldiv_unit dut (
      .CLK    (CLK),
      .RST    (RST),
      .start  (start),
      .op     (op),
      .A      (A),
      .B      (B),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      if (o[2] && !DIV_EN) return 32'h0;
      case (o)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
         3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
      endcase
   endfunction

   // One operation; poke>0 re-asserts start with junk at that in-flight cycle (must be ignored).
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int poke);
      int          k, lat;
      bit          seen;
      logic [31:0] exp;
      exp = ref_res(o, a, b);
      lat = (o[2] && (!DIV_EN || b == 0)) ? 1 : 33;
      @(negedge CLK);
      start = 1'b1; op = o; A = a; B = b;
      @(posedge CLK); #1;
      chk("busy_after_start", {31'b0, busy}, 32'd1);
      chk("done_one_cycle", {31'b0, done}, 32'd0);
      chk("result_held", result, prev_res);
      @(negedge CLK);
      start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
      k = 1; seen = 1'b0;
      while (!seen && k <= 40) begin
         start = (k == poke);
         @(posedge CLK); #1;
         if (done) seen = 1'b1;
         else begin
            chk("busy_in_flight", {31'b0, busy}, 32'd1);
            chk("result_stable", result, prev_res);
            k++;
            @(negedge CLK);
         end
      end
      start = 1'b0;
      chk("latency", k, lat);
      chk("result", result, exp);
      chk("busy_at_done", {31'b0, busy}, 32'd0);
      prev_res = exp;
   endtask

   typedef struct { logic [2:0] o; logic [31:0] a, b; } vec_t;
   vec_t dir[$];

   initial begin
      RST = 1'b1; start = 1'b0; op = '0; A = '0; B = '0; prev_res = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      @(negedge CLK); RST = 1'b0;

      dir.push_back('{OP_MUL,    32'd7,        32'hFFFFFFFD});
      dir.push_back('{OP_MULH,   32'h80000000, 32'h80000000});
      dir.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF});
      dir.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF});
      dir.push_back('{OP_DIV,    32'hFFFFFFF9, 32'd2});
      dir.push_back('{OP_REM,    32'hFFFFFFF9, 32'd2});
      dir.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF});
      dir.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF});
      dir.push_back('{OP_DIV,    32'd5,        32'd0});
      dir.push_back('{OP_REM,    32'hFFFFFFFB, 32'd0});
      dir.push_back('{OP_DIVU,   32'd5,        32'd0});
      dir.push_back('{OP_REMU,   32'd9,        32'd0});
      dir.push_back('{OP_DIVU,   32'd10,       32'd2});
      dir.push_back('{OP_MUL,    32'd6,        32'd7});
      foreach (dir[i]) do_op(dir[i].o, dir[i].a, dir[i].b, 0);

      // start while busy must be ignored
      do_op(OP_MULHU, 32'h12345678, 32'h9ABCDEF0, 5);
      do_op(OP_DIVU, 32'd100, 32'd7, 12);

      for (int i = 0; i < 60; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
         do_op(3'($urandom), ra, rb, 0);
      end
      @(posedge CLK); #1;
      chk("done_drops", {31'b0, done}, 32'd0);

      // Asynchronous abort at CALC iteration 10
      do_op(OP_MUL, 32'd6, 32'd7, 0);
      @(negedge CLK);
      start = 1'b1; op = OP_MUL; A = $urandom; B = $urandom;
      @(posedge CLK);
      @(negedge CLK); start = 1'b0;
      repeat (10) @(posedge CLK);
      #2 RST = 1'b1;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_result", result, 32'd0);
      @(negedge CLK); RST = 1'b0; prev_res = '0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK); #1;
         chk("no_done_after_abort", {31'b0, done}, 32'd0);
      end
      do_op(OP_MULH, 32'hFFFFFFF0, 32'd3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
